// File: rtl/kmer_window_buffer_pkg.sv
// kmer_window_buffer_pkg
//   Shared constants and types for the k-mer window buffer that feeds the
//   minhash k-mer hasher.
//   Optional build macro used by the top: KMER_WINDOW_SKIP_N_EN.
package kmer_window_buffer_pkg;

   localparam int KMER_BUFFER_HASHER_BASE_BITS   = 4;
   localparam int KMER_BUFFER_HASHER_GENOME_BTYE = 2 * KMER_BUFFER_HASHER_BASE_BITS;
   localparam int KMER_BUFFER_HASHER_KMER_LEN    = 8;

   localparam int KMER_WINDOW_BASES = 2 * KMER_BUFFER_HASHER_KMER_LEN;
   localparam int KMER_POS_W        = 16;
   localparam logic [KMER_BUFFER_HASHER_BASE_BITS-1:0] KMER_N_CODE = 4'hF;

   typedef logic [KMER_BUFFER_HASHER_BASE_BITS-1:0]                   base_t;
   typedef logic [KMER_WINDOW_BASES*KMER_BUFFER_HASHER_BASE_BITS-1:0] kmer_t;

endpackage

// File: rtl/kmer_window_buffer_unpacker.sv
// kmer_byte_unpacker
//   Latches one genome byte (two bases) and releases it one base per cycle,
//   earlier base (high nibble) first.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     in_valid/in_ready   byte handshake; in_byte, in_last
//     base_take           consumer can take a base this cycle
//     shift               a base is consumed this cycle
//     base, base_last     current base; set on the final base of a read
module kmer_byte_unpacker
   import kmer_window_buffer_pkg::*;
#(
   parameter int BASE_LEN = KMER_BUFFER_HASHER_BASE_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*BASE_LEN-1:0] in_byte,
   input  logic                  in_last,
   input  logic                  base_take,
   output logic                  shift,
   output logic [BASE_LEN-1:0]   base,
   output logic                  base_last
);

   logic [2*BASE_LEN-1:0] pend_byte;
   logic [1:0]            pend_cnt;
   logic                  pend_last;
   // Holds in_ready low while in reset and for the first edge after release.
   logic                  armed;

   assign shift     = (pend_cnt != 2'd0) && base_take;
   assign base      = (pend_cnt == 2'd2) ? pend_byte[2*BASE_LEN-1:BASE_LEN]
                                         : pend_byte[BASE_LEN-1:0];
   assign base_last = pend_last && (pend_cnt == 2'd1);
   // A new byte may land in the same cycle the last pending base leaves.
   assign in_ready  = armed && ((pend_cnt == 2'd0) || ((pend_cnt == 2'd1) && shift));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         pend_byte <= '0;
         pend_cnt  <= 2'd0;
         pend_last <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (in_valid && in_ready) begin
            pend_byte <= in_byte;
            pend_cnt  <= 2'd2;
            pend_last <= in_last;
         end else if (shift) begin
            pend_cnt  <= pend_cnt - 2'd1;
         end
      end
   end

endmodule

// File: rtl/kmer_window_buffer.sv
// kmer_window_buffer
//   Sliding window of K = 2*KMER_BYTES bases over a genome byte stream.
//   Emits one k-mer per base step with its read-relative start position.
//   Build option: KMER_WINDOW_SKIP_N_EN -- a base equal to N_CODE empties
//   the window so no k-mer containing it is ever emitted.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     in_valid/in_ready     byte handshake; in_byte ([7:4] earlier base), in_last
//     out_valid/out_ready   k-mer handshake; out_kmer (oldest base in MSBs),
//                           out_pos, out_last
//     short_read            one-cycle pulse: read ended with fewer than K bases
module kmer_window_buffer
   import kmer_window_buffer_pkg::*;
#(
   parameter int BASE_LEN   = KMER_BUFFER_HASHER_BASE_BITS,
   parameter int KMER_BYTES = KMER_BUFFER_HASHER_KMER_LEN,
   parameter int POS_W      = KMER_POS_W
`ifdef KMER_WINDOW_SKIP_N_EN
   ,
   parameter logic [BASE_LEN-1:0] N_CODE = KMER_N_CODE
`endif
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [2*BASE_LEN-1:0]            in_byte,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [2*KMER_BYTES*BASE_LEN-1:0] out_kmer,
   output logic [POS_W-1:0]                 out_pos,
   output logic                             out_last,
   output logic                             short_read
);

   localparam int K  = 2 * KMER_BYTES;
   localparam int KW = K * BASE_LEN;
   localparam int FW = $clog2(K + 1);

   logic                shift;
   logic [BASE_LEN-1:0] base;
   logic                base_last;

   logic [FW-1:0]    fill;
   logic [POS_W-1:0] base_cnt;

   logic [KW-1:0]    new_window;
   logic [FW-1:0]    fill_inc;
   logic             full_next;
   logic [FW-1:0]    fill_d;
   logic             kmer_ok;
   logic             short_cond;
   logic [POS_W-1:0] pos_next;
   logic [POS_W-1:0] cnt_next;

   kmer_byte_unpacker #(
      .BASE_LEN (BASE_LEN)
   ) u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .in_last   (in_last),
      .base_take (!out_valid || out_ready),
      .shift     (shift),
      .base      (base),
      .base_last (base_last)
   );

   // out_kmer doubles as the window: it is loaded with the shifted window on
   // every base step and never otherwise, so the two are always identical.
   // Stale bases left over from a previous read are harmless because fill
   // gates emission.
   assign new_window = {out_kmer[KW-BASE_LEN-1:0], base};
   assign fill_inc   = fill + FW'(1);
   assign full_next  = (fill_inc >= FW'(K));
   assign pos_next   = base_cnt + POS_W'(1) - POS_W'(K);
   assign cnt_next   = (&base_cnt) ? base_cnt : base_cnt + POS_W'(1);

   always_comb begin
      fill_d     = full_next ? FW'(K) : fill_inc;
      kmer_ok    = full_next;
      short_cond = !full_next;
`ifdef KMER_WINDOW_SKIP_N_EN
      if (base == N_CODE) begin
         fill_d  = '0;
         kmer_ok = 1'b0;
      end
      // fill restarts on N, so the read length must come from base_cnt.
      short_cond = (base_cnt < POS_W'(K - 1));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill       <= '0;
         base_cnt   <= '0;
         out_valid  <= 1'b0;
         out_kmer   <= '0;
         out_pos    <= '0;
         out_last   <= 1'b0;
         short_read <= 1'b0;
      end else if (shift) begin
         out_valid <= kmer_ok;
         out_kmer  <= new_window;
         out_pos   <= pos_next;
         out_last  <= base_last;
         if (base_last) begin
            fill       <= '0;
            base_cnt   <= '0;
            short_read <= short_cond;
         end else begin
            fill       <= fill_d;
            base_cnt   <= cnt_next;
            short_read <= 1'b0;
         end
      end else begin
         short_read <= 1'b0;
         if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kmer_window_buffer.sv
module tb_kmer_window_buffer;

   localparam int K = 16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_kmer;
   logic [15:0] out_pos;
   logic        out_last;
   logic        short_read;

   kmer_window_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_kmer   (out_kmer),
      .out_pos    (out_pos),
      .out_last   (out_last),
      .short_read (short_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] kmer;
      logic [15:0] pos;
      logic        last;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] rd[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_short = 0;
   int got_short = 0;
   int xfer_cnt = 0;
   bit mon_en = 0;
   int rmode = 0;
   bit stall_done = 0;

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: every K-base window of the read, in order.
   task automatic model_read();
      logic [3:0] bs[$];
      int n;
      foreach (rd[i]) begin
         bs.push_back(rd[i][7:4]);
         bs.push_back(rd[i][3:0]);
      end
      n = bs.size();
      for (int i = K - 1; i < n; i++) begin
         exp_t e;
         bit clean = 1;
         e.kmer = '0;
         for (int j = i - K + 1; j <= i; j++) begin
            e.kmer = {e.kmer[59:0], bs[j]};
`ifdef KMER_WINDOW_SKIP_N_EN
            if (bs[j] == 4'hF) clean = 0;
`endif
         end
         e.pos  = 16'(i - K + 1);
         e.last = (i == n - 1);
         if (clean) sbq.push_back(e);
      end
      if (n < K) exp_short++;
   endtask

   task automatic send_read(input bit last_flag, input bit hold, input bit do_model,
                            output int first_acc, output int last_acc);
      if (do_model) model_read();
      first_acc = 0;
      last_acc  = 0;
      for (int i = 0; i < rd.size(); i++) begin
         int w = 0;
         in_valid = 1'b1;
         in_byte  = rd[i];
         in_last  = last_flag && (i == rd.size() - 1);
         @(negedge clk);
         while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         check_eq("in_accept", in_ready, 1);
         if (i == 0) first_acc = cyc;
         last_acc = cyc;
         @(posedge clk);
         #1;
      end
      if (!hold) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic drain();
      int w = 0;
      while (sbq.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      repeat (20) @(posedge clk);
      #1;
      check_eq("drain", sbq.size(), 0);
      check_eq("short_cnt", got_short, exp_short);
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (short_read) got_short++;
         if (out_valid) begin
            if (sbq.size() == 0) begin
               check_eq("unexpected_kmer", out_valid, 0);
            end else begin
               check_eq("kmer", out_kmer, sbq[0].kmer);
               check_eq("pos", out_pos, sbq[0].pos);
               check_eq("last", out_last, sbq[0].last);
               if (out_ready) begin
                  void'(sbq.pop_front());
                  xfer_cnt++;
               end
            end
         end
      end
   end

   // Downstream ready driver
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rmode == 0) begin
            out_ready = 1'b1;
         end else if (out_valid && !stall_done) begin
            out_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               @(negedge clk);
               if (h == 2) begin
                  check_eq("stall_in_ready", in_ready, 0);
                  check_eq("stall_valid", out_valid, 1);
               end
               @(posedge clk);
               #1;
            end
            stall_done = 1;
            out_ready  = 1'b1;
         end else begin
            out_ready = ~out_ready;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fa, la, fb, lb, x0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_byte  = '0;
      in_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_kmer", out_kmer, 0);
      check_eq("rst_out_pos", out_pos, 0);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_short", short_read, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ready_after_rst", in_ready, 1);
      mon_en = 1;

      // Single 18-base read
      rd = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01};
      send_read(1, 0, 1, fa, la);
      drain();

      // Short read then a normal read
      rd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
      send_read(1, 0, 1, fa, la);
      rd = '{8'h98, 8'h76, 8'h54, 8'h32, 8'h10, 8'hAB, 8'hCD, 8'hE2};
      send_read(1, 0, 1, fa, la);
      drain();

      // Toggling ready with a 5-cycle stall
      rmode = 1;
      stall_done = 0;
      rd = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01};
      send_read(1, 0, 1, fa, la);
      drain();
      check_eq("stall_happened", stall_done, 1);
      rmode = 0;
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back reads with in_valid held high
      rd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_read(1, 1, 1, fa, la);
      rd = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h06, 8'h17, 8'h28};
      send_read(1, 0, 1, fb, lb);
      check_eq("b2b_gap", fb - la, 2);
      drain();

      // Reset in the middle of a read (10 bases in)
      rd = '{8'h13, 8'h57, 8'h9B, 8'hDE, 8'h24};
      send_read(0, 0, 0, fa, la);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      x0 = xfer_cnt;
      rd = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86, 8'h97, 8'hA8};
      send_read(1, 0, 1, fa, la);
      drain();
      check_eq("post_rst_count", xfer_cnt - x0, 1);

      // Read with an N at base index 3
      x0 = xfer_cnt;
      rd = '{8'h12, 8'h3F, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hE0, 8'h12, 8'h34};
      send_read(1, 0, 1, fa, la);
      drain();
`ifdef KMER_WINDOW_SKIP_N_EN
      check_eq("n_read_count", xfer_cnt - x0, 1);
`else
      check_eq("n_read_count", xfer_cnt - x0, 5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
